wb_trace_buffer: RTL and testbench

- Consumer-side trace capture for the 5-stage MIPS pipeline.
- Samples each committed writeback (PC plus result) from the core's WB stage and timestamps it with a free-running cycle counter.
- Buffers samples in a small FIFO and streams them to a downstream logger or checker over a valid/ready handshake.
- Replaces cycle-by-cycle polling of pc_out/alu_result with a lossless (or loss-counted) event stream.

---
 rtl/mips_trace_pkg.sv | 21 ++
 rtl/trace_fifo.sv | 69 ++++++
 rtl/wb_trace_buffer.sv | 94 +++++++++
 tb/tb_wb_trace_buffer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_trace_pkg.sv
// Shared definitions for the MIPS writeback trace path.
// A trace entry is {pc, data, cycle}; pc occupies the top bits so a packed
// entry can be split by simple slicing at the FIFO output.
package mips_trace_pkg;

    localparam int TRACE_CYC_W = 16;

    typedef struct packed {
        logic [31:0]            pc;
        logic [31:0]            data;
        logic [TRACE_CYC_W-1:0] cycle;
    } trace_entry_t;

    localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

    // Packed entry width for a non-default timestamp width.
    function automatic int trace_entry_w(input int cyc_w);
        return 64 + cyc_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push, din   write request and data (ignored when full without a pop)
//   pop         read request (ignored when empty)
//   dout        head entry; reads 0 while empty
//   full, empty status flags derived from level
//   level       occupancy, 0..DEPTH
module trace_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

    // Gate dout so the head reads 0 whenever nothing is buffered.
    assign dout = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; stale words are never visible because dout is
    // gated by empty and only written slots are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace capture for the 5-stage MIPS pipeline.
// Timestamps each committed writeback with a free-running cycle counter,
// buffers it in an FWFT FIFO and streams it out over valid/ready.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   trace_en              capture enable
//   wb_valid/wb_pc/wb_data committed writeback from the WB stage
//   trace_valid/ready     output handshake; trace_pc/data/cycle is the head
//   level                 FIFO occupancy
//   dropped               saturating count of events lost to a full FIFO
//   overflow              sticky flag, set on the first drop
module wb_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CYC_W  = TRACE_CYC_W,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trace_en,
    input  logic                     wb_valid,
    input  logic [31:0]              wb_pc,
    input  logic [31:0]              wb_data,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_pc,
    output logic [31:0]              trace_data,
    output logic [CYC_W-1:0]         trace_cycle,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DROP_W-1:0]        dropped,
    output logic                     overflow
);

    localparam int EW = trace_entry_w(CYC_W);

    logic [CYC_W-1:0]  cycle_q, cycle_d;
    logic [DROP_W-1:0] dropped_q, dropped_d;
    logic              overflow_q, overflow_d;
    logic              push, pop, drop;
    logic              fifo_full, fifo_empty;
    logic [EW-1:0]     fifo_din, fifo_dout;

    assign trace_valid = ~fifo_empty;

    always_comb begin
        pop  = ~fifo_empty & trace_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push = trace_en & wb_valid & (~fifo_full | pop);
        drop = trace_en & wb_valid & fifo_full & ~pop;

        fifo_din   = {wb_pc, wb_data, cycle_q};
        cycle_d    = cycle_q + CYC_W'(1);
        overflow_d = overflow_q | drop;
        dropped_d  = dropped_q;
        if (drop && (dropped_q != '1)) begin
            dropped_d = dropped_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q    <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

    trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign trace_pc    = fifo_dout[EW-1 -: 32];
    assign trace_data  = fifo_dout[EW-33 -: 32];
    assign trace_cycle = fifo_dout[CYC_W-1:0];
    assign dropped     = dropped_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

    localparam int DEPTH    = 8;
    localparam int CYC_W    = 16;
    localparam int DROP_W   = 2;
    localparam int LW       = $clog2(DEPTH) + 1;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              trace_en = 1'b0;
    logic              wb_valid = 1'b0;
    logic [31:0]       wb_pc = '0;
    logic [31:0]       wb_data = '0;
    logic              trace_ready = 1'b0;
    logic              trace_valid;
    logic [31:0]       trace_pc;
    logic [31:0]       trace_data;
    logic [CYC_W-1:0]  trace_cycle;
    logic [LW-1:0]     level;
    logic [DROP_W-1:0] dropped;
    logic              overflow;

    always #5 clk = ~clk;

    wb_trace_buffer #(
        .DEPTH  (DEPTH),
        .CYC_W  (CYC_W),
        .DROP_W (DROP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trace_en    (trace_en),
        .wb_valid    (wb_valid),
        .wb_pc       (wb_pc),
        .wb_data     (wb_data),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_pc    (trace_pc),
        .trace_data  (trace_data),
        .trace_cycle (trace_cycle),
        .level       (level),
        .dropped     (dropped),
        .overflow    (overflow)
    );

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      data;
        logic [CYC_W-1:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   mcyc = 0;
    int   mdrop = 0;
    bit   movf = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge: compare DUT outputs against the scoreboard.
    task automatic check_outputs();
        check_val("valid", 64'(trace_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            check_val("head_pc",    64'(trace_pc),    64'(sb[0].pc));
            check_val("head_data",  64'(trace_data),  64'(sb[0].data));
            check_val("head_cycle", 64'(trace_cycle), 64'(sb[0].cyc));
        end else begin
            check_val("idle_pc",    64'(trace_pc),    64'(0));
            check_val("idle_data",  64'(trace_data),  64'(0));
            check_val("idle_cycle", 64'(trace_cycle), 64'(0));
        end
        check_val("level",    64'(level),    64'(sb.size()));
        check_val("dropped",  64'(dropped),  64'(mdrop));
        check_val("overflow", 64'(overflow), 64'(movf));
    endtask

    // One clock: check, drive, update model, advance to next falling edge.
    task automatic step(input bit en, input bit v, input logic [31:0] pc,
                        input logic [31:0] data, input bit rdy);
        bit full, pop, push, drop;
        check_outputs();
        trace_en    = en;
        wb_valid    = v;
        wb_pc       = pc;
        wb_data     = data;
        trace_ready = rdy;
        full = (sb.size() == DEPTH);
        pop  = (sb.size() != 0) && rdy;
        push = en && v && (!full || pop);
        drop = en && v && full && !pop;
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back({pc, data, CYC_W'(mcyc)});
        if (drop) begin
            movf = 1'b1;
            if (mdrop < DROP_MAX) mdrop++;
        end
        @(posedge clk);
        mcyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        trace_en    = 1'b0;
        wb_valid    = 1'b0;
        trace_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        mcyc  = 0;
        mdrop = 0;
        movf  = 1'b0;
    endtask

    initial begin
        // Reset then idle.
        do_reset();
        repeat (5) step(0, 0, 32'h0, 32'h0, 0);

        // Single event captured at counter 3, held while not ready.
        do_reset();
        repeat (3) step(0, 0, 32'h0, 32'h0, 0);
        step(1, 1, 32'h0000_0004, 32'h0000_000A, 0);
        check_val("single_cycle", 64'(trace_cycle), 64'd3);
        check_val("single_pc",    64'(trace_pc),    64'h4);
        repeat (3) step(0, 0, 32'h0, 32'h0, 0);
        step(0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 32'h0, 32'h0, 0);

        // Burst of 8 fills the FIFO, the 9th is dropped.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 1, 32'h100 + 32'(4 * i), 32'(i * 3 + 1), 0);
        step(1, 1, 32'hDEAD_BEEF, 32'hBAD0_0009, 0);
        check_val("burst_level",    64'(level),    64'd8);
        check_val("burst_dropped",  64'(dropped),  64'd1);
        check_val("burst_overflow", 64'(overflow), 64'd1);
        // Full with simultaneous push and pop.
        step(1, 1, 32'h200, 32'h55, 1);
        check_val("fullpp_level",   64'(level),   64'd8);
        check_val("fullpp_dropped", 64'(dropped), 64'd1);
        repeat (9) step(0, 0, 32'h0, 32'h0, 1);

        // Capture disabled: pulses ignored, counter keeps running.
        step(1, 1, 32'h300, 32'h1, 0);
        step(1, 1, 32'h304, 32'h2, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 32'h400 + 32'(i), 32'hF0 + 32'(i), 0);
        check_val("dis_level", 64'(level), 64'd2);
        step(1, 1, 32'h308, 32'h3, 0);
        repeat (4) step(0, 0, 32'h0, 32'h0, 1);

        // Drop saturation, then reset in the middle of draining.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 1, 32'h500 + 32'(i), 32'(i), 0);
        for (int i = 0; i < 5; i++) step(1, 1, 32'h600 + 32'(i), 32'(i), 0);
        check_val("sat_dropped", 64'(dropped), 64'(DROP_MAX));
        step(0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 32'h0, 32'h0, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_valid",    64'(trace_valid), 64'd0);
        check_val("rst_level",    64'(level),       64'd0);
        check_val("rst_dropped",  64'(dropped),     64'd0);
        check_val("rst_overflow", 64'(overflow),    64'd0);
        check_val("rst_pc",       64'(trace_pc),    64'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        trace_ready = 1'b0;
        sb.delete();
        mcyc  = 0;
        mdrop = 0;
        movf  = 1'b0;
        step(0, 0, 32'h0, 32'h0, 0);
        step(1, 1, 32'h700, 32'h7, 0);
        step(0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 32'h0, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
